seq_det: RTL and testbench



---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det.sv | 56 +++++
 tb/tb_seq_det.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and state encoding for the 10010 serial detector.
package seq_det_pkg;

    localparam int         STATE_W = 3;
    localparam logic [4:0] PATTERN = 5'b10010;

    // Each state names the longest pattern prefix that matches the stream suffix.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        A    = 3'd1,
        B    = 3'd2,
        C    = 3'd3,
        D    = 3'd4,
        E    = 3'd5
    } state_t;

endpackage

// File: rtl/seq_det.sv
// seq_det: overlapping 10010 detector on a serial bit stream with debug state output.
// Define SEQ_DET_REG_OUT_EN for a registered z that lags the Mealy flag by one cycle.
module seq_det
    import seq_det_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    output logic               z,
    output logic [STATE_W-1:0] state
);

    state_t r_state;
    state_t w_next;
    logic   w_hit;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = x ? A : IDLE;
            A:       w_next = x ? A : B;
            B:       w_next = x ? A : C;
            C:       w_next = x ? D : IDLE;
            D:       w_next = x ? A : E;
            E:       w_next = x ? A : C;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // The final pattern bit arrives live on x while the prefix "1001" is held.
    assign w_hit = (r_state == D) && (x == PATTERN[0]);
    assign state = r_state;

`ifdef SEQ_DET_REG_OUT_EN
    logic r_z;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_z <= 1'b0;
        else
            r_z <= w_hit;
    end

    assign z = r_z;
`else
    assign z = w_hit;
`endif

endmodule

// File: tb/tb_seq_det.sv
// tb_seq_det: table-driven and directed checks for the seq_det 10010 detector.
module tb_seq_det;

`ifdef SEQ_DET_REG_OUT_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    typedef struct {
        logic       x;
        logic [2:0] st;
        logic       zm;
        logic       zr;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       x;
    logic       z;
    logic [2:0] state;

    int n_chk;
    int n_err;

    seq_det dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .z     (z),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    vec_t        tbl [22];
    logic [23:0] word;
    logic [3:0]  hist;
    logic        m;
    logic        prev_m;
    logic        bitv;
    int          pulses;

    initial begin
        n_chk = 0;
        n_err = 0;
        // Stimulus: x driven on the falling edge, state is the value before the next rising edge.
        tbl[0]  = '{1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd2, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd3, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'd4, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 3'd5, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 3'd3, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd4, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'd5, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 3'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 3'd1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 3'd2, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 3'd3, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 3'd0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 3'd1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 3'd2, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 3'd3, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 3'd4, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 3'd1, 1'b0, 1'b0};

        // Reset held with x toggling
        rst = 1'b0;
        x   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #5 x = ~x;
            #1;
            chk("reset_state", int'(state), 0);
            chk("reset_z", int'(z), 0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            x = tbl[i].x;
            #1;
            chk($sformatf("tbl[%0d].state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("tbl[%0d].z", i), int'(z), int'(REG ? tbl[i].zr : tbl[i].zm));
        end

        // Clean restart
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("restart_state", int'(state), 0);
        rst = 1'b1;

        // Reset asserted between edges after the prefix 1001
        @(negedge clk); x = 1'b1;
        @(negedge clk); x = 1'b0;
        @(negedge clk); x = 1'b0;
        @(negedge clk); x = 1'b1;
        @(posedge clk);
        #1;
        chk("midmatch_prefix_state", int'(state), 4);
        #2;
        x   = 1'b0;
        rst = 1'b0;
        #1;
        chk("midmatch_async_state", int'(state), 0);
        chk("midmatch_async_z", int'(z), 0);
        @(negedge clk);
        rst = 1'b1;
        x   = 1'b0;
        #1;
        chk("midmatch_release_state", int'(state), 0);
        chk("midmatch_release_z", int'(z), 0);
        @(negedge clk);
        #1;
        chk("midmatch_after_state", int'(state), 0);
        chk("midmatch_after_z", int'(z), 0);

        // Rotating 24-bit stream against a sliding-window reference
        word   = 24'h0890F4;
        hist   = 4'b0000;
        prev_m = 1'b0;
        pulses = 0;
        for (int i = 0; i < 72; i++) begin
            bitv = word[23 - (i % 24)];
            @(negedge clk);
            x = bitv;
            #1;
            m = ({hist, bitv} == 5'b10010);
            chk($sformatf("rot[%0d].z", i), int'(z), int'(REG ? prev_m : m));
            if (z)
                pulses++;
            hist   = {hist[2:0], bitv};
            prev_m = m;
        end
        chk("rot_pulse_count", pulses, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
